// File: rtl/round_state_mux.sv
// rtl/round_state_mux.sv - AES round state register with load/feedback select and round sequencing
// Optional build macro ROUND_MUX_STALL_EN adds a stall input that freezes RUN.
module round_state_mux #(
  parameter int WIDTH      = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ROUND_MUX_STALL_EN
  input  logic             stall,
`endif
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] fb_data,
  output logic [WIDTH-1:0] state_out,
  output logic [CNT_W-1:0] round_idx,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);

  fsm_t             state, state_nxt;
  logic [WIDTH-1:0] state_q;
  logic [CNT_W-1:0] idx_q;
  logic             hold;
  logic             advance;

`ifdef ROUND_MUX_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign advance = (state == RUN) && !hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_valid) state_nxt = RUN;
      RUN:     if (advance && (idx_q == LAST_IDX)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == IDLE);
    busy       = (state == RUN);
    out_valid  = (state == DONE);
  end

  // The select is implied by FSM state: load in IDLE, feedback in RUN, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            state_q <= load_data;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (advance) begin
            state_q <= fb_data;
            idx_q   <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) idx_q <= '0;
        end
        default: begin
          state_q <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign state_out = state_q;
  assign out_data  = state_q;
  assign round_idx = idx_q;

endmodule
